cmplx_square_stream: RTL and testbench

- Streaming, parametrised fixed-point complex squarer. Successor to the single-width HPS-attached complex-square datapath.
- Computes z^2 (mode 0) or z^2 + c (mode 1, one Mandelbrot step) per sample.
- Uses a 3-stage pipeline with valid/ready handshakes on both sides and a credit-protected output FIFO, so backpressure never drops a sample.
- Sits between the HPS-to-fabric bridge adapter and downstream consumers on the fabric clock.

---
 rtl/cmplx_square_pkg.sv | 43 ++++
 rtl/cmplx_square_fifo.sv | 76 +++++++
 rtl/cmplx_square_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_cmplx_square_stream.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplx_square_pkg.sv
// cmplx_square_pkg
//   Shared definitions for the streaming complex squarer:
//     - mode encoding (MODE_SQ, MODE_SQ_ADD_C)
//     - pipeline depth and the number of registered valid stages
//     - reduce_word(): narrows a wide signed value to w bits and flags
//       overflow. With CMPLX_SQUARE_SAT_EN defined the value saturates,
//       otherwise the caller keeps the low w bits (wrap).
//   Build macro: CMPLX_SQUARE_SAT_EN (undefined = wrap, defined = saturate).
package cmplx_square_pkg;

    localparam logic MODE_SQ       = 1'b0;
    localparam logic MODE_SQ_ADD_C = 1'b1;

    // S1 and S2 are registers; S3 is combinational into the FIFO write port,
    // so only PIPE_DEPTH-1 valid bits are ever in flight.
    localparam int PIPE_DEPTH    = 3;
    localparam int PIPE_VLD_REGS = PIPE_DEPTH - 1;

    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } red_t;

    // Narrow v to a signed w-bit range (w <= 62).
    function automatic red_t reduce_word(input logic signed [63:0] v, input int w);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        red_t               r;
        maxv  = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv  = -(64'sd1 <<< (w - 1));
        r.ovf = (v > maxv) || (v < minv);
        r.val = v;
`ifdef CMPLX_SQUARE_SAT_EN
        if (v > maxv) begin
            r.val = maxv;
        end else if (v < minv) begin
            r.val = minv;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/cmplx_square_fifo.sv
// cmplx_square_fifo
//   Synchronous first-word-fall-through FIFO. The head word is visible on
//   o_data whenever o_valid is high; i_pop consumes it on the next edge.
//   Push and pop in the same cycle are both honoured, including when full.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     i_push, i_data     write strobe and word
//     i_pop              consume head (ignored when empty)
//     o_data, o_valid    head word and its valid
//     o_count            number of stored words (0..DEPTH)
module cmplx_square_fifo
    import cmplx_square_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/cmplx_square_stream.sv
// cmplx_square_stream
//   Streaming fixed-point complex squarer: z^2 (mode 0) or z^2 + c (mode 1).
//   S1 registers the operands, S2 registers the scaled products, S3 adds c,
//   narrows to WIDTH bits and writes the FIFO. Input acceptance is credit
//   based (FIFO occupancy plus in-flight samples), so the pipeline never
//   stalls and no sample is dropped under backpressure.
//   Build macro: CMPLX_SQUARE_SAT_EN selects saturation instead of wrap.
//   Ports:
//     clk_clk, reset_reset           clock, asynchronous active-high reset
//     in_valid/in_ready              input handshake
//     in_re, in_im, in_c_re, in_c_im operands, signed Q(WIDTH-FRAC).FRAC
//     in_mode                        MODE_SQ or MODE_SQ_ADD_C
//     out_valid/out_ready            output handshake (FIFO head)
//     out_re, out_im, out_ovf        result and its overflow flag
//     busy                           pipeline or FIFO non-empty
//     ovf_sticky, ovf_clr            sticky overflow and its clear
//     sample_cnt                     accepted-sample counter
module cmplx_square_stream
    import cmplx_square_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic [WIDTH-1:0] in_c_re,
    input  logic [WIDTH-1:0] in_c_im,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_ovf,
    output logic             busy,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = 2 * WIDTH + 1;

    // ---------------- credit / accept ----------------
    logic          w_accept;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_credit;

    logic r_v1;
    logic r_v2;

    assign w_inflight = {{(CW-1){1'b0}}, r_v1} + {{(CW-1){1'b0}}, r_v2};
    assign w_credit   = w_fifo_count + w_inflight;
    // Held low combinationally while reset is asserted.
    assign in_ready   = ~reset_reset & (w_credit < CW'(DEPTH));
    assign w_accept   = in_valid & in_ready;

    // ---------------- S1: operand registers ----------------
    logic signed [WIDTH-1:0] r_a1;
    logic signed [WIDTH-1:0] r_b1;
    logic signed [WIDTH-1:0] r_cre1;
    logic signed [WIDTH-1:0] r_cim1;
    logic                    r_mode1;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_v1    <= 1'b0;
            r_a1    <= '0;
            r_b1    <= '0;
            r_cre1  <= '0;
            r_cim1  <= '0;
            r_mode1 <= MODE_SQ;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a1    <= in_re;
                r_b1    <= in_im;
                r_cre1  <= in_c_re;
                r_cim1  <= in_c_im;
                r_mode1 <= in_mode;
            end
        end
    end

    // Products and scaling, registered into S2.
    logic signed [PW-1:0] w_a_x;
    logic signed [PW-1:0] w_b_x;
    logic signed [PW-1:0] w_aa;
    logic signed [PW-1:0] w_bb;
    logic signed [PW-1:0] w_ab;
    logic signed [PW:0]   w_re_f;
    logic signed [PW:0]   w_im_f;
    logic signed [PW:0]   w_re_sh;
    logic signed [PW:0]   w_im_sh;

    assign w_a_x   = {{WIDTH{r_a1[WIDTH-1]}}, r_a1};
    assign w_b_x   = {{WIDTH{r_b1[WIDTH-1]}}, r_b1};
    assign w_aa    = w_a_x * w_a_x;
    assign w_bb    = w_b_x * w_b_x;
    assign w_ab    = w_a_x * w_b_x;
    assign w_re_f  = {w_aa[PW-1], w_aa} - {w_bb[PW-1], w_bb};
    assign w_im_f  = {w_ab, 1'b0};
    // Arithmetic shift floors toward negative infinity.
    assign w_re_sh = w_re_f >>> FRAC;
    assign w_im_sh = w_im_f >>> FRAC;

    // ---------------- S2: scaled result registers ----------------
    logic signed [PW:0]      r_re2;
    logic signed [PW:0]      r_im2;
    logic signed [WIDTH-1:0] r_cre2;
    logic signed [WIDTH-1:0] r_cim2;
    logic                    r_mode2;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_v2    <= 1'b0;
            r_re2   <= '0;
            r_im2   <= '0;
            r_cre2  <= '0;
            r_cim2  <= '0;
            r_mode2 <= MODE_SQ;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_re2   <= w_re_sh;
                r_im2   <= w_im_sh;
                r_cre2  <= r_cre1;
                r_cim2  <= r_cim1;
                r_mode2 <= r_mode1;
            end
        end
    end

    // ---------------- S3: add c, narrow, FIFO write ----------------
    logic signed [WIDTH-1:0] w_cre_sel;
    logic signed [WIDTH-1:0] w_cim_sel;
    logic signed [PW+1:0]    w_re_s3;
    logic signed [PW+1:0]    w_im_s3;
    red_t                    w_re_red;
    red_t                    w_im_red;
    logic                    w_ovf;
    logic                    w_push;
    logic [FW-1:0]           w_push_data;

    assign w_cre_sel = (r_mode2 == MODE_SQ_ADD_C) ? r_cre2 : {WIDTH{1'b0}};
    assign w_cim_sel = (r_mode2 == MODE_SQ_ADD_C) ? r_cim2 : {WIDTH{1'b0}};
    assign w_re_s3   = {r_re2[PW], r_re2} + {{(WIDTH+2){w_cre_sel[WIDTH-1]}}, w_cre_sel};
    assign w_im_s3   = {r_im2[PW], r_im2} + {{(WIDTH+2){w_cim_sel[WIDTH-1]}}, w_cim_sel};

    assign w_re_red  = reduce_word({{(64-PW-2){w_re_s3[PW+1]}}, w_re_s3}, WIDTH);
    assign w_im_red  = reduce_word({{(64-PW-2){w_im_s3[PW+1]}}, w_im_s3}, WIDTH);

    assign w_ovf       = w_re_red.ovf | w_im_red.ovf;
    assign w_push      = r_v2;
    assign w_push_data = {w_ovf, w_im_red.val[WIDTH-1:0], w_re_red.val[WIDTH-1:0]};

    // Upper bits of the narrowed words are intentionally discarded.
    logic w_unused_hi;
    assign w_unused_hi = ^{w_re_red.val[63:WIDTH], w_im_red.val[63:WIDTH]};

    // ---------------- output FIFO ----------------
    logic [FW-1:0] w_head;
    logic          w_fifo_valid;
    logic          w_pop;

    assign w_pop = w_fifo_valid & out_ready;

    cmplx_square_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    // Outputs read zero while the FIFO is empty.
    assign out_valid = w_fifo_valid;
    assign out_re    = w_fifo_valid ? w_head[WIDTH-1:0]       : '0;
    assign out_im    = w_fifo_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign out_ovf   = w_fifo_valid & w_head[FW-1];
    assign busy      = r_v1 | r_v2 | (w_fifo_count != '0);

    // ---------------- status counters ----------------
    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_sample_cnt;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_ovf_sticky <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            // A new overflow wins over a clear in the same cycle.
            if (w_push && w_ovf) begin
                r_ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_sticky <= 1'b0;
            end
            if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
        end
    end

    assign ovf_sticky = r_ovf_sticky;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_cmplx_square_stream.sv
module tb_cmplx_square_stream;

    localparam int W  = 16;
    localparam int F  = 12;
    localparam int D  = 8;
    localparam int CN = 32;
`ifdef CMPLX_SQUARE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_re, in_im, in_c_re, in_c_im;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_re, out_im;
    logic          out_ovf;
    logic          busy;
    logic          ovf_sticky;
    logic          ovf_clr;
    logic [CN-1:0] sample_cnt;

    always #5 clk = ~clk;

    cmplx_square_stream #(.WIDTH(W), .FRAC(F), .DEPTH(D), .CNT_W(CN)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_c_re     (in_c_re),
        .in_c_im     (in_c_im),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_ovf     (out_ovf),
        .busy        (busy),
        .ovf_sticky  (ovf_sticky),
        .ovf_clr     (ovf_clr),
        .sample_cnt  (sample_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         ovf;
    } res_t;

    // Complex arithmetic on real integers: scale by 2^-F with floor, add c,
    // then fit into W signed bits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] cr, input logic [W-1:0] ci,
                                   input logic mode);
        longint sa, sb, re, im, hi, lo;
        res_t   r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        re = sa * sa - sb * sb;
        im = 2 * sa * sb;
        re = re >>> F;
        im = im >>> F;
        if (mode) begin
            re = re + longint'($signed(cr));
            im = im + longint'($signed(ci));
        end
        hi    = (64'sd1 <<< (W - 1)) - 1;
        lo    = -hi - 1;
        r.ovf = (re > hi) || (re < lo) || (im > hi) || (im < lo);
        if (SAT) begin
            if (re > hi) re = hi;
            if (re < lo) re = lo;
            if (im > hi) im = hi;
            if (im < lo) im = lo;
        end
        r.re = re[W-1:0];
        r.im = im[W-1:0];
        return r;
    endfunction

    // ---------------- stream scoreboard ----------------
    res_t q[$];
    bit   mon_en = 1'b0;
    int   n_acc  = 0;
    int   n_out  = 0;

    always @(negedge clk) begin
        res_t e;
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("stream_re", out_re, e.re);
                    check("stream_im", out_im, e.im);
                    check("stream_ovf", out_ovf, e.ovf);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_re, in_im, in_c_re, in_c_im, in_mode));
                n_acc++;
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [W-1:0] a, b, cr, ci;
        logic         mode;
        logic [W-1:0] er, ei;
        logic         eo;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        n_acc = 0;
        n_out = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_sample();
        logic [W-1:0] v[4];
        for (int k = 0; k < 4; k++) begin
            v[k] = W'($urandom);
            if ($urandom_range(0, 1) == 1) v[k] = {{3{v[k][12]}}, v[k][12:0]};
        end
        in_re   = v[0];
        in_im   = v[1];
        in_c_re = v[2];
        in_c_im = v[3];
        in_mode = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int cyc;
        bit saw;

        tbl[0]  = '{a:16'h1000, b:16'h0000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'h1000, ei:16'h0000, eo:1'b0};
        tbl[1]  = '{a:16'h1000, b:16'h1000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'h0000, ei:16'h2000, eo:1'b0};
        tbl[2]  = '{a:16'h1000, b:16'h1000, cr:16'hF000, ci:16'h0800, mode:1'b1, er:16'hF000, ei:16'h2800, eo:1'b0};
        tbl[3]  = '{a:16'h6000, b:16'h0000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:(SAT ? 16'h7FFF : 16'h4000), ei:16'h0000, eo:1'b1};
        tbl[4]  = '{a:16'hF000, b:16'h0000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'h1000, ei:16'h0000, eo:1'b0};
        tbl[5]  = '{a:16'h0000, b:16'h1000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'hF000, ei:16'h0000, eo:1'b0};
        tbl[6]  = '{a:16'h0000, b:16'h0001, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'hFFFF, ei:16'h0000, eo:1'b0};
        tbl[7]  = '{a:16'h8000, b:16'h0000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:(SAT ? 16'h7FFF : 16'h0000), ei:16'h0000, eo:1'b1};
        tbl[8]  = '{a:16'h0000, b:16'h6000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:(SAT ? 16'h8000 : 16'hC000), ei:16'h0000, eo:1'b1};
        tbl[9]  = '{a:16'h2C00, b:16'h0000, cr:16'h1000, ci:16'h0000, mode:1'b1, er:(SAT ? 16'h7FFF : 16'h8900), ei:16'h0000, eo:1'b1};
        tbl[10] = '{a:16'h2000, b:16'h2000, cr:16'h0000, ci:16'h0000, mode:1'b0, er:16'h0000, ei:(SAT ? 16'h7FFF : 16'h8000), eo:1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_c_re   = '0;
        in_c_im   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        tick();

        // Directed table: one sample at a time into an empty FIFO.
        for (int i = 0; i < NV; i++) begin
            in_re    = tbl[i].a;
            in_im    = tbl[i].b;
            in_c_re  = tbl[i].cr;
            in_c_im  = tbl[i].ci;
            in_mode  = tbl[i].mode;
            in_valid = 1'b1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 10) begin
                tick();
                cyc++;
            end
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd3);
            check($sformatf("vec%0d_re", i), out_re, tbl[i].er);
            check($sformatf("vec%0d_im", i), out_im, tbl[i].ei);
            check($sformatf("vec%0d_ovf", i), out_ovf, tbl[i].eo);
            tick();
            if (tbl[i].eo) begin
                check($sformatf("vec%0d_sticky_set", i), ovf_sticky, 1);
                repeat (2) tick();
                check($sformatf("vec%0d_sticky_hold", i), ovf_sticky, 1);
                ovf_clr = 1'b1;
                tick();
                ovf_clr = 1'b0;
                check($sformatf("vec%0d_sticky_clr", i), ovf_sticky, 0);
            end else begin
                check($sformatf("vec%0d_sticky_clear", i), ovf_sticky, 0);
            end
        end
        check("directed_sample_cnt", sample_cnt, NV);

        // Backpressure: out_ready low, in_valid held high.
        do_reset();
        mon_en    = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_sample();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(n_acc), D);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_sample_cnt", sample_cnt, D);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        check("bp_drain_timeout", 64'(busy), 0);
        check("bp_outputs", 64'(n_out), D);
        check("bp_queue_empty", 64'(q.size()), 0);
        check("bp_in_ready_back", in_ready, 1);

        // Random traffic with random backpressure.
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if (n_acc >= 1000) begin
                in_valid = 1'b0;
                break;
            end
            rand_sample();
            in_valid = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        cyc = 0;
        while ((busy || q.size() != 0) && cyc < 2000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        out_ready = 1'b1;
        tick();
        check("rand_accepts", 64'(n_acc), 1000);
        check("rand_sample_cnt", sample_cnt, 1000);
        check("rand_outputs", 64'(n_out), 1000);
        check("rand_queue_empty", 64'(q.size()), 0);
        check("rand_idle", busy, 0);
        mon_en = 1'b0;

        // Reset with samples in flight: 3 in the FIFO, 2 in the pipeline.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_sample();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("mid_busy_before", busy, 1);
        check("mid_cnt_before", sample_cnt, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sample_cnt", sample_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        saw       = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid || busy) saw = 1'b1;
        end
        check("mid_rst_no_stale", saw, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
